// File: rtl/maze_pkg.sv
// Shared types and widths for the maze ROM arbiter and its tag return pipeline.
package maze_pkg;

   typedef enum logic [0:0] {VIDPRI_S, GAMEPRI_S} arb_state_t;
   typedef enum logic {OWN_VID, OWN_GAME} rom_owner_t;

   localparam int MAZE_ADDR_W = 11;
   localparam int MAZE_DATA_W = 16;
   localparam int WAIT_W      = 4;

endpackage

// File: rtl/rom_tag_pipe.sv
// DEPTH-stage {valid, owner} shift register that tracks which requester owns
// each in-flight ROM read; flush drops every outstanding tag.
module rom_tag_pipe
   import maze_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic       clk,
   input  logic       flush,
   input  logic       in_valid,
   input  rom_owner_t in_owner,
   output logic       out_valid,
   output rom_owner_t out_owner
);

   logic       valid_q [DEPTH];
   rom_owner_t owner_q [DEPTH];

   always_ff @(posedge clk) begin
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            owner_q[i] <= OWN_VID;
         end
      end else begin
         valid_q[0] <= in_valid;
         owner_q[0] <= in_owner;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            owner_q[i] <= owner_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_owner = owner_q[DEPTH-1];

endmodule

// File: rtl/maze_rom_arbiter.sv
// Shares the maze ROM port between the video renderer (fixed priority) and the
// game controller, with a starvation counter that guarantees the game a slot.
//
// state     | meaning
// VIDPRI_S  | video wins on conflict; game counts consecutive denied cycles
// GAMEPRI_S | game starved for STARVE_LIMIT cycles; game wins this cycle
module maze_rom_arbiter
   import maze_pkg::*;
#(
   parameter int ADDR_W       = MAZE_ADDR_W,
   parameter int DATA_W       = MAZE_DATA_W,
   parameter int ROM_LAT      = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_vid_req,
   input  logic [ADDR_W-1:0] i_vid_addr,
   output logic              o_vid_gnt,
   output logic              o_vid_rvalid,
   output logic [DATA_W-1:0] o_vid_rdata,
   input  logic              i_game_req,
   input  logic [ADDR_W-1:0] i_game_addr,
   output logic              o_game_gnt,
   output logic              o_game_rvalid,
   output logic [DATA_W-1:0] o_game_rdata,
   output logic              o_rom_en,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [DATA_W-1:0] i_rom_data,
   output logic              o_vid_stall
);

   localparam logic [WAIT_W-1:0] LIMIT    = WAIT_W'(STARVE_LIMIT);
   localparam logic [WAIT_W-1:0] LIMIT_M1 = WAIT_W'(STARVE_LIMIT - 1);

   arb_state_t        state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic              tag_valid;
   rom_owner_t        tag_owner;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= VIDPRI_S;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      if (o_game_gnt || !i_game_req) begin
         wait_nxt = '0;
      end else if (wait_cnt != LIMIT) begin
         wait_nxt = wait_cnt + 1'b1;
      end
      case (state)
         VIDPRI_S: begin
            if (i_game_req && !o_game_gnt && wait_cnt == LIMIT_M1) begin
               state_nxt = GAMEPRI_S;
            end
         end
         GAMEPRI_S: begin
            // Priority lasts one cycle: the game is granted or has withdrawn.
            if (o_game_gnt || !i_game_req) begin
               state_nxt = VIDPRI_S;
            end
         end
         default: state_nxt = VIDPRI_S;
      endcase
   end

   always_comb begin
      o_vid_gnt  = 1'b0;
      o_game_gnt = 1'b0;
      if (!rst) begin
         case (state)
            GAMEPRI_S: begin
               o_game_gnt = i_game_req;
               o_vid_gnt  = i_vid_req & ~i_game_req;
            end
            default: begin
               o_vid_gnt  = i_vid_req;
               o_game_gnt = i_game_req & ~i_vid_req;
            end
         endcase
      end
      o_rom_en    = o_vid_gnt | o_game_gnt;
      o_vid_stall = ~rst & i_vid_req & ~o_vid_gnt;
      if (o_vid_gnt) begin
         o_rom_addr = i_vid_addr;
      end else if (o_game_gnt) begin
         o_rom_addr = i_game_addr;
      end else begin
         o_rom_addr = '0;
      end
   end

   rom_tag_pipe #(
      .DEPTH (ROM_LAT)
   ) u_tag_pipe (
      .clk       (clk),
      .flush     (rst),
      .in_valid  (o_rom_en),
      .in_owner  (o_game_gnt ? OWN_GAME : OWN_VID),
      .out_valid (tag_valid),
      .out_owner (tag_owner)
   );

   assign o_vid_rvalid  = tag_valid && (tag_owner == OWN_VID);
   assign o_game_rvalid = tag_valid && (tag_owner == OWN_GAME);
   assign o_vid_rdata   = o_vid_rvalid  ? i_rom_data : '0;
   assign o_game_rdata  = o_game_rvalid ? i_rom_data : '0;

endmodule
